// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per clock with a registered borrow.
// Start/busy/done handshake; result and flags are registered and only update on completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_subtractor: CHUNK must be >= 1 and divide WIDTH, WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;
  logic   busy_d, done_d;
  logic   load, step, last;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
  logic             brw;
  logic             a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   sub_c;

  // One CHUNK-wide subtract step; the extra MSB of sub_c is the borrow out of the chunk.
  always_comb begin
    sub_c  = {1'b0, a_sr[CHUNK-1:0]} - {1'b0, b_sr[CHUNK-1:0]} - {{CHUNK{1'b0}}, brw};
    r_next = (r_sr >> CHUNK) | (WIDTH'(sub_c[CHUNK-1:0]) << (WIDTH - CHUNK));
    last   = (cnt == CW'(N - 1));
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d = state;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        step   = 1'b1;
        busy_d = 1'b1;
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Operand/result shift registers; outputs load only on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b1;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      brw   <= bin;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      cnt   <= '0;
    end else if (step) begin
      a_sr <= a_sr >> CHUNK;
      b_sr <= b_sr >> CHUNK;
      r_sr <= r_next;
      brw  <= sub_c[CHUNK];
      cnt  <= cnt + CW'(1);
      if (last) begin
        diff <= r_next;
        bout <= sub_c[CHUNK];
        ovf  <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
        zero <= (r_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model with per-cycle compare on an 8/1 instance,
// plus directed literal checks on 8/1, 8/4 and 16/2 instances.
module tb_serial_subtractor;

  localparam int unsigned W = 8;
  localparam int unsigned C = 1;
  localparam int unsigned N = W / C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Main instance (8-bit, 1 bit per cycle)
  logic         start = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, bout, ovf, zero;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero));

  // 8-bit, 4 bits per cycle
  logic       s4 = 1'b0, bin4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4, ovf4, zero4;
  logic [7:0] diff4;

  serial_subtractor #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4), .zero(zero4));

  // 16-bit, 2 bits per cycle
  logic        s16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, bout16, ovf16, zero16;
  logic [15:0] diff16;

  serial_subtractor #(.WIDTH(16), .CHUNK(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16), .zero(zero16));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference model: outputs computed from plain integer arithmetic, released N cycles after acceptance.
  logic         m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, m_ovf = 1'b0, m_zero = 1'b1;
  logic [W-1:0] m_diff = '0;
  logic         p_bout = 1'b0, p_ovf = 1'b0, p_zero = 1'b1;
  logic [W-1:0] p_diff = '0;
  int           m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    int u, s;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_diff = '0;
      m_bout = 1'b0; m_ovf = 1'b0; m_zero = 1'b1; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf; m_zero = p_zero;
        end
      end else if (start) begin
        u = int'(a) - int'(b) - int'(bin);
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        p_diff = W'(u);
        p_bout = (u < 0);
        p_ovf  = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
        p_zero = (p_diff == '0);
        m_rem  = N;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cycle{busy,done,bout,ovf,zero,diff}",
          32'({busy, done, bout, ovf, zero, diff}),
          32'({m_busy, m_done, m_bout, m_ovf, m_zero, m_diff}));
  end

  // Issue one start pulse on the main instance; returns at the cycle-1 negedge.
  task automatic go(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
    @(negedge clk);
    a = av; b = bv; bin = binv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_main(input int from, output int cyc);
    cyc = from;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int cyc, pulses;

    repeat (2) @(negedge clk);
    check("reset_values", 32'({busy, done, diff, bout, ovf, zero}), 32'({1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}));
    #2 rst_n = 1'b1;

    go(8'h5A, 8'h3C, 1'b0);
    wait_main(1, cyc);
    check("lat_5A_3C", 32'(cyc), 32'd9);
    check("res_5A_3C", 32'({diff, bout, ovf, zero}), 32'({8'h1E, 1'b0, 1'b0, 1'b0}));

    go(8'h00, 8'h01, 1'b0);
    wait_main(1, cyc);
    check("res_00_01", 32'({diff, bout, ovf, zero}), 32'({8'hFF, 1'b1, 1'b0, 1'b0}));

    go(8'h80, 8'h01, 1'b0);
    wait_main(1, cyc);
    check("res_80_01", 32'({diff, bout, ovf, zero}), 32'({8'h7F, 1'b0, 1'b1, 1'b0}));

    // Start during RUN must be ignored
    go(8'h10, 8'h0F, 1'b1);
    @(negedge clk);
    a = 8'h01; b = 8'h00; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_main(3, cyc);
    check("lat_ignored_start", 32'(cyc), 32'd9);
    check("res_10_0F_bin", 32'({diff, bout, ovf, zero}), 32'({8'h00, 1'b0, 1'b0, 1'b1}));
    count_done(12, pulses);
    check("no_extra_done", 32'(pulses), 32'd0);
    check("hold_after_ignored", 32'(diff), 32'h00);

    // Asynchronous abort mid-RUN
    go(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_values", 32'({busy, done, diff, bout, ovf, zero}), 32'({1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    count_done(12, pulses);
    check("no_done_after_abort", 32'(pulses), 32'd0);
    go(8'h03, 8'h05, 1'b0);
    wait_main(1, cyc);
    check("lat_after_abort", 32'(cyc), 32'd9);
    check("res_03_05", 32'({diff, bout, ovf, zero}), 32'({8'hFE, 1'b1, 1'b0, 1'b0}));

    // CHUNK=4 back-to-back with start held high
    @(negedge clk);
    a4 = 8'hF0; b4 = 8'h0F; s4 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("d4_done_c%0d", k), 32'(done4), 32'((k % 3) == 0));
      check($sformatf("d4_out_c%0d", k), 32'({diff4, bout4}), (k < 3) ? 32'({8'h00, 1'b0}) : 32'({8'hE1, 1'b0}));
    end
    s4 = 1'b0;

    // WIDTH=16, CHUNK=2
    @(negedge clk);
    a16 = 16'h8000; b16 = 16'h0001; bin16 = 1'b1; s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    cyc = 1;
    while (!done16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("d16_lat", 32'(cyc), 32'd9);
    check("d16_res", 32'({diff16, bout16, ovf16, zero16}), 32'({16'h7FFE, 1'b0, 1'b1, 1'b0}));

    // Randomized traffic on the main instance, checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor that computes `diff = a - b - bin` over WIDTH-bit operands by processing CHUNK bits per clock, with the borrow carried between chunks in a register. It generalises the single-bit full subtractor into a resource-lean sequential datapath. It sits behind a start/busy/done handshake so a controller can issue subtractions without wide combinational borrow chains. Status flags (borrow-out, signed overflow, zero) are registered alongside the result.

## Interface
- `WIDTH`, 8: operand and result width in bits; legal range ≥ 2.
- `CHUNK`, 1: bits processed per cycle; must be ≥ 1 and divide WIDTH exactly (elaboration error otherwise).
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request; sampled only when `busy` = 0.
- `a`  input  WIDTH  minuend; captured on the accepted `start` edge.
- `b`  input  WIDTH  subtrahend; captured with `a`.
- `bin`  input  1  borrow-in; captured with `a`.
- `busy`  output  1  high while a subtraction is in progress.
- `done`  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
- `diff`  output  WIDTH  registered difference, modulo 2^WIDTH.
- `bout`  output  1  registered borrow-out; 1 when a < b + bin (unsigned).
- `ovf`  output  1  registered two's-complement overflow.
- `zero`  output  1  registered; 1 when `diff` = 0.

## Operation
- N = WIDTH/CHUNK chunk steps per operation.
- FSM states:
  - IDLE: `busy` = 0, `done` = 0.
  - RUN: `busy` = 1, `done` = 0.
  - DONE: `busy` = 0, `done` = 1.
- IDLE + `start` = 1: latch `a`, `b` into operand shift registers; latch `bin` into the borrow register; clear the chunk counter; go to RUN.
- IDLE + `start` = 0: stay in IDLE.
- RUN, each cycle:
  - Take the low CHUNK bits of each operand shift register and form `{borrow_next, d} = a_chunk - b_chunk - borrow`.
  - Shift `d` into the result shift register from the MSB side.
  - Shift both operand registers right by CHUNK.
  - Increment the counter.
- RUN, on the step where counter = N-1: additionally load the output registers and go to DONE. Loaded values:
  - `diff` = full result.
  - `bout` = final `borrow_next`.
  - `ovf` = (a[W-1] ≠ b[W-1]) & (diff[W-1] ≠ a[W-1]), using the captured operands.
  - `zero` = (diff == 0).
- DONE + `start` = 1: accept the new operands exactly as IDLE does and go to RUN, giving back-to-back operation.
- DONE + `start` = 0: go to IDLE.
- `start` while in RUN is ignored; operands and the in-flight result are unaffected.
- `diff`, `bout`, `ovf`, `zero` hold their last completed values until the next DONE. They never show partial results.
- Input `a`, `b`, `bin` changes after acceptance have no effect.

## Timing
- Reset values:
  - State = IDLE.
  - `busy` = 0, `done` = 0.
  - `diff` = 0, `bout` = 0, `ovf` = 0.
  - `zero` = 1, consistent with `diff` = 0.
  - Internal shift registers, borrow register and counter = 0.
- Reset is asynchronous. Asserting `rst_n` low mid-RUN or in DONE aborts immediately to the reset values, and no `done` pulse is issued. Release is synchronous to `clk` (release synchronisation is provided externally).
- Latency: `start` accepted at edge E0; RUN during cycles 1..N; `done` high in cycle N+1. The outputs update at the same edge that raises `done`.
- Throughput: with `start` held high, one result every N+1 cycles.
- `busy` rises in cycle 1 and falls in cycle N+1.
- Combinational path per cycle is limited to a CHUNK-bit subtract plus borrow; there is no WIDTH-length chain unless CHUNK = WIDTH.
- CHUNK = WIDTH: N = 1, so `done` appears 2 cycles after `start`.

## Test plan
- WIDTH=8, CHUNK=1; a=0x5A, b=0x3C, bin=0, start for one cycle → `busy` high for cycles 1–8; `done` in cycle 9 with diff=0x1E, bout=0, ovf=0, zero=0.
- WIDTH=8, CHUNK=1; two operand sets:
  - a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
  - a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
- WIDTH=8, CHUNK=1; a=0x10, b=0x0F, bin=1 → diff=0x00, zero=1, bout=0. Then pulse start with a=0x01, b=0x00 at cycle 3 → the pulse is ignored and the result is still 0x00.
- WIDTH=8, CHUNK=4; a=0xF0, b=0x0F, bin=0 with `start` held high → `done` in cycles 3, 6, 9…, each with diff=0xE1, bout=0. Previous outputs stay stable between pulses.
- WIDTH=8, CHUNK=1; start a=0x5A, b=0x3C, then drive rst_n low in cycle 4 → all outputs go to reset values immediately; no `done` follows. After release, a=0x03, b=0x05 → diff=0xFE, bout=1 at the normal latency.
- WIDTH=16, CHUNK=2; a=0x8000, b=0x0001, bin=1 → `done` in cycle 9 with diff=0x7FFE, ovf=1, bout=0.
